// File: rtl/wb_bram_pkg.sv
//----------------------------------------------------------------------
// wb_bram_pkg : shared types and helpers for the Wishbone BRAM controller
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package wb_bram_pkg;

  localparam int LAT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    ERR  = 2'd3
  } state_t;

  function automatic logic win_hit(input logic       stb,
                                   input logic       cyc,
                                   input logic [7:0] adr_hi,
                                   input logic [7:0] base);
    return stb & cyc & (adr_hi == base);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_bram_mem.sv
//----------------------------------------------------------------------
// wb_bram_mem : DEPTH x 32 single-port sync-read RAM, byte write enables
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module wb_bram_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_a,
  input  logic [31:0]   i_di,
  output logic [31:0]   o_do
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] w_merged;

  always_comb begin
    w_merged = r_mem[i_a];
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) w_merged[8*b +: 8] = i_di[8*b +: 8];
    end
  end

  // Output always shows the word as it was before this cycle's write.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      o_do <= r_mem[i_a];
      if (|i_we) r_mem[i_a] <= w_merged;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_bram_ctrl.sv
//----------------------------------------------------------------------
// wb_bram_ctrl : Wishbone slave front end for an internal BRAM window
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module wb_bram_ctrl
  import wb_bram_pkg::*;
#(
  parameter logic [7:0] BASE_HI = 8'h38,
  parameter int         DEPTH   = 1024,
  parameter int         RD_LAT  = 10,
  parameter int         WR_LAT  = 10
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);

  localparam int               AW       = $clog2(DEPTH);
  localparam logic [31:0]      c_DEPTH  = 32'(DEPTH);
  localparam logic [LAT_W-1:0] c_RD_LAT = LAT_W'(RD_LAT);
  localparam logic [LAT_W-1:0] c_WR_LAT = LAT_W'(WR_LAT);

  state_t           r_state;
  logic [LAT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_ack;
  logic             r_err;
  logic             r_busy;
  logic             r_we;
  logic             r_cap;

  logic [21:0]      w_widx;
  logic             w_hit;
  logic             w_in_range;
  logic             w_mem_en;
  logic [3:0]       w_mem_we;
  logic [31:0]      w_mem_do;
  logic [LAT_W-1:0] w_lat;
  logic             w_unused;

  assign w_widx     = wbs_adr_i[23:2];
  assign w_hit      = win_hit(wbs_stb_i, wbs_cyc_i, wbs_adr_i[31:24], BASE_HI);
  assign w_in_range = ({10'd0, w_widx} < c_DEPTH);
  assign w_mem_en   = (r_state == IDLE) && w_hit && w_in_range;
  assign w_mem_we   = wbs_we_i ? wbs_sel_i : 4'b0000;
  assign w_lat      = wbs_we_i ? c_WR_LAT : c_RD_LAT;
  assign w_unused   = ^wbs_adr_i[1:0];

  wb_bram_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk (wb_clk_i),
    .i_en  (w_mem_en),
    .i_we  (w_mem_we),
    .i_a   (w_widx[AW-1:0]),
    .i_di  (wbs_dat_i),
    .o_do  (w_mem_do)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_cap   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_cap <= 1'b0;
      if (r_cap) r_rdata <= w_mem_do;
      unique case (r_state)
        IDLE: begin
          if (w_hit && w_in_range) begin
            r_we   <= wbs_we_i;
            r_cap  <= !wbs_we_i;
            r_busy <= 1'b1;
            // A latency of one skips WAIT so ack lands right after acceptance.
            if (w_lat == LAT_W'(1)) begin
              r_state <= ACK;
              r_ack   <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= w_lat - LAT_W'(1);
            end
          end else if (w_hit) begin
            r_state <= ERR;
            r_err   <= 1'b1;
            r_we    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (!wbs_cyc_i) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else if (r_cnt == LAT_W'(1)) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        ACK, ERR: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // While the capture is still pending the RAM output is forwarded directly.
  assign wbs_dat_o = (r_ack && !r_we) ? (r_cap ? w_mem_do : r_rdata) : 32'h0;
  assign wbs_ack_o = r_ack;
  assign wbs_err_o = r_err;
  assign busy_o    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_wb_bram_ctrl.sv
//----------------------------------------------------------------------
// tb_wb_bram_ctrl : randomized bench for wb_bram_ctrl against a word-array model
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_wb_bram_ctrl;

  localparam int DEPTH = 1024;
  localparam int POOL  = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb  [2];
  logic        cyc  [2];
  logic        we   [2];
  logic [3:0]  sel  [2];
  logic [31:0] dati [2];
  logic [31:0] adr  [2];
  logic        ack  [2];
  logic        err  [2];
  logic        busy [2];
  logic [31:0] dato [2];

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [2][POOL];

  always #5 clk = ~clk;

  wb_bram_ctrl #(.BASE_HI(8'h38), .DEPTH(DEPTH), .RD_LAT(10), .WR_LAT(10)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb[0]), .wbs_cyc_i(cyc[0]), .wbs_we_i(we[0]), .wbs_sel_i(sel[0]),
    .wbs_dat_i(dati[0]), .wbs_adr_i(adr[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .wbs_dat_o(dato[0]), .busy_o(busy[0])
  );

  wb_bram_ctrl #(.BASE_HI(8'h38), .DEPTH(DEPTH), .RD_LAT(1), .WR_LAT(3)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb[1]), .wbs_cyc_i(cyc[1]), .wbs_we_i(we[1]), .wbs_sel_i(sel[1]),
    .wbs_dat_i(dati[1]), .wbs_adr_i(adr[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .wbs_dat_o(dato[1]), .busy_o(busy[1])
  );

  function automatic int lat_of(int u, bit w);
    if (u == 0) return 10;
    return w ? 3 : 1;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drop(int u);
    stb[u] = 1'b0;
    cyc[u] = 1'b0;
    we[u]  = 1'b0;
    sel[u] = 4'h0;
    dati[u] = 32'h0;
    adr[u] = 32'h0;
  endtask

  // Flags are packed as {ack, err, busy}.
  task automatic xact(int u, bit w, logic [31:0] a, logic [3:0] s, logic [31:0] d, int abort_at);
    bit          hit     = (a[31:24] == 8'h38);
    int          widx    = int'(a[23:2]);
    bit          inr     = (widx < DEPTH);
    int          lat     = lat_of(u, w);
    int          lat_end = inr ? lat : 1;
    int          kmax    = hit ? lat_end + 2 : 20;
    logic [31:0] exp_rd  = 32'h0;
    bit          e_ack, e_err, e_busy;
    if (hit && inr) begin
      if (w) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) model[u][widx][8*b +: 8] = d[8*b +: 8];
      end
      exp_rd = model[u][widx];
    end
    @(negedge clk);
    stb[u] = 1'b1; cyc[u] = 1'b1; we[u] = w; sel[u] = s; dati[u] = d; adr[u] = a;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      #1;
      e_ack  = hit && inr && (abort_at == 0) && (k == lat);
      e_err  = hit && !inr && (k == 1);
      e_busy = hit && (k <= lat_end) && !(abort_at > 0 && k > abort_at);
      check($sformatf("u%0d a=%h k=%0d flags", u, a, k),
            {29'd0, ack[u], err[u], busy[u]}, {29'd0, e_ack, e_err, e_busy});
      check($sformatf("u%0d a=%h k=%0d dat", u, a, k),
            dato[u], (e_ack && !w) ? exp_rd : 32'h0);
      @(negedge clk);
      if ((hit && k == lat_end) || k == abort_at || k == kmax) drop(u);
    end
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    stb[0] = 1'b1; cyc[0] = 1'b1; we[0] = 1'b0; sel[0] = 4'hF; adr[0] = 32'h3800_0008;
    repeat (3) @(posedge clk);
    #1;
    check("busy before reset", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("flags in reset", {29'd0, ack[0], err[0], busy[0]}, 32'd0);
    check("dat in reset", dato[0], 32'h0);
    @(negedge clk);
    drop(0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("flags after reset", {29'd0, ack[0], err[0], busy[0]}, 32'd0);
  endtask

  initial begin
    int          u, r, lat, ab, widx;
    bit          w;
    logic [31:0] a;
    logic [7:0]  hi;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) drop(i);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset flags u%0d", i), {29'd0, ack[i], err[i], busy[i]}, 32'd0);
      check($sformatf("reset dat u%0d", i), dato[i], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 2; i++)
      for (int j = 0; j < POOL; j++)
        xact(i, 1'b1, 32'h3800_0000 + 32'(j * 4), 4'hF, $urandom, 0);

    xact(0, 1'b1, 32'h3800_0010, 4'hF, 32'hDEAD_BEEF, 0);
    xact(0, 1'b0, 32'h3800_0010, 4'hF, 32'h0, 0);
    xact(0, 1'b1, 32'h3800_0020, 4'hF, 32'h1122_3344, 0);
    xact(0, 1'b1, 32'h3800_0020, 4'h5, 32'hAAAA_AAAA, 0);
    xact(0, 1'b0, 32'h3800_0020, 4'hF, 32'h0, 0);
    check("merge model", model[0][8], 32'h11AA_33AA);
    xact(0, 1'b0, 32'h3800_1000, 4'hF, 32'h0, 0);
    xact(0, 1'b1, 32'h3800_1000, 4'hF, 32'hFFFF_FFFF, 0);
    xact(0, 1'b0, 32'h3800_0000, 4'hF, 32'h0, 0);
    xact(0, 1'b0, 32'h3900_0000, 4'hF, 32'h0, 0);
    xact(0, 1'b1, 32'h3800_0004, 4'hF, 32'h5A5A_1234, 3);
    xact(0, 1'b0, 32'h3800_0004, 4'hF, 32'h0, 0);
    xact(0, 1'b1, 32'h3800_000C, 4'h0, 32'h1234_5678, 0);
    xact(0, 1'b0, 32'h3800_000C, 4'hF, 32'h0, 0);

    xact(1, 1'b1, 32'h3800_0010, 4'hF, 32'hCAFE_F00D, 0);
    xact(1, 1'b0, 32'h3800_0010, 4'hF, 32'h0, 0);
    xact(1, 1'b0, 32'h3800_0014, 4'hF, 32'h0, 0);
    xact(1, 1'b0, 32'h3800_1000, 4'hF, 32'h0, 0);

    reset_mid_wait();
    xact(0, 1'b0, 32'h3800_0008, 4'hF, 32'h0, 0);

    for (int n = 0; n < 60; n++) begin
      u  = $urandom_range(0, 1);
      w  = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      ab = 0;
      if (r == 0) begin
        hi = 8'($urandom_range(0, 255));
        if (hi == 8'h38) hi = 8'h00;
        a = {hi, 24'($urandom)};
      end else if (r == 1) begin
        widx = $urandom_range(DEPTH, 4194303);
        a = {8'h38, 22'(widx), 2'($urandom)};
      end else begin
        widx = $urandom_range(0, POOL - 1);
        a = {8'h38, 22'(widx), 2'($urandom)};
        lat = lat_of(u, w);
        if (lat >= 3 && $urandom_range(0, 4) == 0) ab = $urandom_range(1, lat - 1);
      end
      xact(u, w, a, 4'($urandom), $urandom, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_bram_ctrl.md
Name: wb_bram_ctrl

Overview:
Parametrised Wishbone-slave BRAM controller for the user project area. It is the next generation of the fixed-delay BRAM bridge.
- Decodes a configurable 16 MB window.
- Has independent read and write ack latencies.
- Commits exactly one memory access per transaction.
- Returns an error for out-of-range words.
- Aborts cleanly when the master drops cyc.
- Sits between the management SoC Wishbone bus and an internal synchronous-read memory.

Parameters:
BASE_HI, 8'h38, required value of wbs_adr_i[31:24] for a window hit
DEPTH, 1024, memory depth in 32-bit words; power of two, 2..2^22
RD_LAT, 10, cycles from request acceptance to read ack; legal range 1..255
WR_LAT, 10, cycles from request acceptance to write ack; legal range 1..255

Ports:
wb_clk_i  input  1  single clock; all logic on its rising edge
wb_rst_ni  input  1  asynchronous, active-low reset
wbs_stb_i  input  1  Wishbone strobe
wbs_cyc_i  input  1  Wishbone cycle
wbs_we_i  input  1  1 = write, 0 = read
wbs_sel_i  input  4  byte lane enables; bit n selects byte n
wbs_dat_i  input  32  write data
wbs_adr_i  input  32  byte address
wbs_ack_o  output  1  registered transfer acknowledge
wbs_err_o  output  1  registered error acknowledge
wbs_dat_o  output  32  read data; valid only while ack is high
busy_o  output  1  high whenever the FSM is not IDLE

Behaviour:
- Reset (wb_rst_ni = 0, asynchronous): state = IDLE, latency counter = 0, rdata register = 0. Outputs ack, err and busy are 0; wbs_dat_o = 0. Memory contents are not reset.
- Address decode:
  - AW = $clog2(DEPTH).
  - widx = wbs_adr_i[23:2]; the memory address is widx[AW-1:0].
  - hit = stb & cyc & (adr[31:24] == BASE_HI).
  - in_range = (widx < DEPTH), i.e. adr[23:2+AW] all zero.
  - adr[1:0] is ignored.
- Acceptance cycle T0 is IDLE with hit asserted.
  - If in_range: memory en is asserted for that cycle only. Byte write enables = wbs_we_i ? wbs_sel_i : 4'b0.
  - A write commits at the T0 edge.
  - A read's memory data appears at T0+1 and is captured into rdata at the T0+1 edge.
  - The counter is loaded with (we ? WR_LAT : RD_LAT) - 1, and the FSM enters WAIT.
- FSM states:
  - IDLE: on hit & in_range go to WAIT. On hit & !in_range go to ERR; there is no memory access. With no hit, stay in IDLE.
  - WAIT: the counter decrements each cycle. When counter == 0 go to ACK. If cyc drops, go to IDLE without ack (abort).
  - ACK: wbs_ack_o = 1 for exactly one cycle. wbs_dat_o = rdata for reads, 0 for writes. Then go to IDLE.
  - ERR: wbs_err_o = 1 for exactly one cycle, wbs_dat_o = 0, then go to IDLE.
- Latency: ack is high in cycle T0 + LAT, so LAT = 1 gives ack in the cycle after acceptance.
  - RD_LAT = 1 is legal because the rdata register forwards the memory output while capturing.
  - When RD_LAT = 1, wbs_dat_o is driven from bram do in the ACK cycle.
- A new request is not accepted during WAIT, ACK or ERR. Back-to-back requests are spaced at least LAT+1 cycles apart.
- Abort: a write has already committed at T0 and stays committed. A read has no side effect. No ack or err is issued for the aborted transfer.
- A write with sel = 0000 is acked normally and modifies no bytes.
- A stb/cyc pair outside the window is ignored: no ack, no err, and busy stays 0.
- Reset asserted mid-transaction returns to IDLE immediately, with no ack.
- Each transaction performs exactly one memory enable. This is the key change from the old bridge, which held en for the whole delay.
- wbs_dat_o is 0 in every cycle where ack is 0.

Decomposition:
- Shared package wb_bram_pkg holds:
  - state enum: IDLE, WAIT, ACK, ERR
  - LAT_W = 8, the counter width
  - the window-hit helper function
- One sub-module, wb_bram_mem: DEPTH x 32 single-port synchronous-read RAM.
  - Ports: clk, en, we[3:0], a[AW-1:0], di[31:0], do[31:0].
  - Per-byte write enables.
  - Read-before-write output on the port.

Test Plan:
- Write 0xDEADBEEF to 0x3800_0010 with sel = F, then read it back -> ack at T0+10 for both; read data = 0xDEADBEEF; busy high for cycles T0+1..T0+10.
- Write 0x11223344 to 0x3800_0020 with sel = F, then write 0xAAAAAAAA to 0x3800_0020 with sel = 0101, then read -> 0x11AA33AA.
- Read 0x3800_1000 with DEPTH = 1024 (widx = 1024, out of range) -> err at T0+1, ack stays 0, dat = 0, memory untouched.
- Read 0x3900_0000 (wrong BASE_HI) held for 20 cycles -> no ack, no err, busy = 0.
- Write at 0x3800_0004, then drop cyc at T0+3; next read of 0x3800_0004 -> no ack on the aborted write; the read returns the new data (write committed).
- Build with RD_LAT = 1, WR_LAT = 3 and do a read -> ack at T0+1 with correct data. Write -> ack at T0+3. Assert reset during WAIT -> all outputs 0 asynchronously.
